sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; successor to the fixed 4x4-bit core FIFO.
//  Buffers DATA_W-bit words between a producer and a consumer on the same clock.
//  Adds occupancy count, almost-full/almost-empty thresholds, flush, a read-valid strobe
//  and sticky overflow/underflow error flags.
// PARAMETERS
//  DATA_W    4          word width in bits (>=1)
//  DEPTH     4          number of entries; power of two, >=2; ADDR_W = $clog2(DEPTH) (localparam)
//  AF_LEVEL  DEPTH-1    almost_full asserts when count >= AF_LEVEL
//  AE_LEVEL  1          almost_empty asserts when count <= AE_LEVEL
// PORTS
//  clk           in   1         clock; all state updates on posedge
//  reset         in   1         synchronous, active-high reset
//  wr_en         in   1         write request
//  wr_data       in   DATA_W    write word
//  rd_en         in   1         read request
//  flush         in   1         synchronous clear of contents and error flags
//  rd_data       out  DATA_W    read word, registered
//  rd_valid      out  1         1-cycle strobe: rd_data updated this cycle
//  count         out  ADDR_W+1  current occupancy, 0..DEPTH
//  empty_flag    out  1         count == 0
//  full_flag     out  1         count == DEPTH
//  almost_full   out  1         count >= AF_LEVEL
//  almost_empty  out  1         count <= AE_LEVEL
//  overflow      out  1         sticky: write attempted while full and not accepted
//  underflow     out  1         sticky: read attempted while empty
// BEHAVIOUR
//  Reset (sync, priority over all): pointers=0, count=0, rd_data=0, rd_valid=0,
//   overflow=0, underflow=0; hence empty_flag=1, full_flag=0, almost_empty=1,
//   almost_full=(AF_LEVEL==0). Storage array is not cleared.
//  Priority per edge: reset > flush > read/write.
//  flush: as reset except rd_data holds value; wr/rd same cycle are dropped, no flags set.
//  Accept rules (evaluated on pre-edge state):
//   rd_acc = rd_en & ~empty_flag
//   wr_acc = wr_en & (~full_flag | rd_acc)   (write on full allowed only with accepted read)
//  Write: mem[wr_ptr] <= wr_data; wr_ptr wraps DEPTH-1 -> 0.
//  Read: rd_data <= mem[rd_ptr] at the edge; rd_valid=1 for exactly that following cycle;
//   rd_ptr wraps DEPTH-1 -> 0. Without rd_acc: rd_valid=0, rd_data holds.
//  Latency: word written at edge N readable by rd_en at edge N+1 (no fall-through on empty).
//  count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither; never
//   exceeds DEPTH or goes below 0.
//  Empty + rd_en + wr_en: write accepted, read rejected, underflow set, count -> 1.
//  overflow <= 1 on wr_en & ~wr_acc; underflow <= 1 on rd_en & ~rd_acc; both clear only on
//   reset/flush. Rejected operations never alter pointers, count or memory.
//  All flags are decoded from registered count; no combinational path inputs -> outputs.
// TESTING
//  1 Reset: reset=1 two edges -> count=0, empty_flag=1, full_flag=0, rd_valid=0, overflow=0.
//  2 Fill (DEPTH=4): write F,E,D,9 -> full_flag=1 after 4th edge, count=4, almost_full=1
//    from 3rd; 5th write 0x3 -> overflow=1, count stays 4, 0x3 never read back.
//  3 Drain: 4 reads -> rd_data F,E,D,9 each with rd_valid one cycle after rd_en;
//    empty_flag=1 after 4th; 5th read -> underflow=1, rd_valid=0, rd_data holds 9.
//  4 Full + rd_en + wr_en(0xA): count stays 4, overflow stays 0; subsequent drain yields
//    E,D,9,A; wrap-around: 3 fill/drain rounds of 4 words preserve order.
//  5 Empty + rd_en + wr_en(0x5): count=1, underflow=1; next read returns 5.
//  6 flush with wr_en at count=2 and overflow=1 -> count=0, empty_flag=1, overflow=0,
//    write dropped; reset asserted mid-stream behaves identically and rd_data -> 0.

Source files
------------

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with occupancy, thresholds, flush and sticky error flags
module sync_fifo_param #(
    parameter int DATA_W   = 4,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    input  logic                       flush,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty_flag,
    output logic                       full_flag,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_acc;
    logic              wr_acc;

    // Flags come straight from the count register, so no input reaches an output combinationally
    assign empty_flag   = (count == '0);
    assign full_flag    = (count == DEPTH_C);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A full FIFO can still take a write when a read frees a slot on the same edge
    assign rd_acc = rd_en & ~empty_flag;
    assign wr_acc = wr_en & (~full_flag | rd_acc);

    always_ff @(posedge clk) begin
        if (!reset && !flush && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + ADDR_W'(1);
            end
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en && !rd_acc) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param (DEPTH=4, DATA_W=4)
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_data = 4'h0;
    logic       rd_en = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic [2:0] count;
    logic       empty_flag;
    logic       full_flag;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int errors = 0;
    int checks = 0;

    sync_fifo_param #(.DATA_W(4), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .flush(flush), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
        .empty_flag(empty_flag), .full_flag(full_flag), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // One clock edge with the given request pattern; outputs are stable 1ns after the edge
    task automatic op(input logic w, input logic [3:0] d, input logic r);
        wr_en = w; wr_data = d; rd_en = r;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty_flag !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty_flag); end
        checks++; if (full_flag !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full_flag); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got=%b exp=1", almost_empty); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
        checks++; if (rd_data !== 4'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    endtask

    task automatic test_fill();
        logic [3:0] vals [4] = '{4'hF, 4'hE, 4'hD, 4'h9};
        for (int i = 0; i < 4; i++) begin
            op(1'b1, vals[i], 1'b0);
            checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
            checks++; if (almost_full !== (i >= 2)) begin errors++; $display("FAIL fill_almost_full[%0d] got=%b exp=%b", i, almost_full, i >= 2); end
            checks++; if (full_flag !== (i == 3)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full_flag, i == 3); end
            checks++; if (almost_empty !== (i == 0)) begin errors++; $display("FAIL fill_almost_empty[%0d] got=%b exp=%b", i, almost_empty, i == 0); end
        end
        op(1'b1, 4'h3, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_overflow_count got=%0d exp=4", count); end
    endtask

    task automatic test_drain();
        logic [3:0] vals [4] = '{4'hF, 4'hE, 4'hD, 4'h9};
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 4'h0, 1'b1);
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL drain_rd_valid[%0d] got=%b exp=1", i, rd_valid); end
            checks++; if (rd_data !== vals[i]) begin errors++; $display("FAIL drain_rd_data[%0d] got=%h exp=%h", i, rd_data, vals[i]); end
        end
        checks++; if (empty_flag !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty_flag); end
        op(1'b0, 4'h0, 1'b1);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL drain_underflow got=%b exp=1", underflow); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL drain_under_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (rd_data !== 4'h9) begin errors++; $display("FAIL drain_hold_rd_data got=%h exp=9", rd_data); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drain_overflow_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_full_rw();
        logic [3:0] vals [4] = '{4'hF, 4'hE, 4'hD, 4'h9};
        logic [3:0] exp_drain [4] = '{4'hE, 4'hD, 4'h9, 4'hA};
        logic [3:0] d;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 4; i++) op(1'b1, vals[i], 1'b0);
        op(1'b1, 4'hA, 1'b1);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullrw_count got=%0d exp=4", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullrw_overflow got=%b exp=0", overflow); end
        checks++; if (rd_data !== 4'hF || rd_valid !== 1'b1) begin errors++; $display("FAIL fullrw_read got=%h/%b exp=f/1", rd_data, rd_valid); end
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 4'h0, 1'b1);
            checks++; if (rd_data !== exp_drain[i]) begin errors++; $display("FAIL fullrw_drain[%0d] got=%h exp=%h", i, rd_data, exp_drain[i]); end
        end
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) op(1'b1, 4'((r * 5 + k * 3 + 1) & 15), 1'b0);
            for (int k = 0; k < 4; k++) begin
                op(1'b0, 4'h0, 1'b1);
                d = 4'((r * 5 + k * 3 + 1) & 15);
                checks++; if (rd_data !== d) begin errors++; $display("FAIL wrap[%0d][%0d] got=%h exp=%h", r, k, rd_data, d); end
            end
        end
        checks++; if (empty_flag !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL wrap_end got=%b/%b exp=1/0", empty_flag, underflow); end
    endtask

    task automatic test_empty_rw();
        op(1'b1, 4'h5, 1'b1);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL emptyrw_count got=%0d exp=1", count); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL emptyrw_underflow got=%b exp=1", underflow); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL emptyrw_rd_valid got=%b exp=0", rd_valid); end
        op(1'b0, 4'h0, 1'b1);
        checks++; if (rd_data !== 4'h5 || rd_valid !== 1'b1) begin errors++; $display("FAIL emptyrw_read got=%h/%b exp=5/1", rd_data, rd_valid); end
        op(1'b0, 4'h0, 1'b0);
        checks++; if (rd_valid !== 1'b0 || rd_data !== 4'h5) begin errors++; $display("FAIL emptyrw_strobe got=%b/%h exp=0/5", rd_valid, rd_data); end
    endtask

    task automatic test_flush_reset();
        for (int i = 1; i <= 5; i++) op(1'b1, 4'(i), 1'b0);
        op(1'b0, 4'h0, 1'b1);
        op(1'b0, 4'h0, 1'b1);
        checks++; if (count !== 3'd2 || overflow !== 1'b1 || rd_data !== 4'h2) begin errors++; $display("FAIL flush_setup got=%0d/%b/%h exp=2/1/2", count, overflow, rd_data); end
        flush = 1'b1;
        op(1'b1, 4'h6, 1'b0);
        flush = 1'b0;
        checks++; if (count !== 3'd0 || empty_flag !== 1'b1) begin errors++; $display("FAIL flush_count got=%0d/%b exp=0/1", count, empty_flag); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL flush_flags got=%b/%b exp=0/0", overflow, underflow); end
        checks++; if (rd_data !== 4'h2 || rd_valid !== 1'b0) begin errors++; $display("FAIL flush_rd_data got=%h/%b exp=2/0", rd_data, rd_valid); end
        op(1'b0, 4'h0, 1'b1);
        checks++; if (underflow !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got=%b/%b exp=1/0", underflow, rd_valid); end
        op(1'b1, 4'h8, 1'b0);
        op(1'b1, 4'h9, 1'b0);
        op(1'b0, 4'h0, 1'b1);
        checks++; if (rd_data !== 4'h8 || count !== 3'd1) begin errors++; $display("FAIL midreset_setup got=%h/%0d exp=8/1", rd_data, count); end
        reset = 1'b1;
        op(1'b1, 4'hC, 1'b1);
        reset = 1'b0;
        checks++; if (count !== 3'd0 || empty_flag !== 1'b1) begin errors++; $display("FAIL midreset_count got=%0d/%b exp=0/1", count, empty_flag); end
        checks++; if (rd_data !== 4'h0 || rd_valid !== 1'b0) begin errors++; $display("FAIL midreset_rd_data got=%h/%b exp=0/0", rd_data, rd_valid); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL midreset_flags got=%b/%b exp=0/0", overflow, underflow); end
        op(1'b1, 4'h7, 1'b0);
        op(1'b0, 4'h0, 1'b1);
        checks++; if (rd_data !== 4'h7 || rd_valid !== 1'b1) begin errors++; $display("FAIL postreset_read got=%h/%b exp=7/1", rd_data, rd_valid); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_rw();
        test_empty_rw();
        test_flush_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
